// File: rtl/la_latrf_if.sv
// Port bundle for the latch-based register file: write request, read address,
// registered read data and the sweep-in-progress flag.
interface la_latrf_if #(
    parameter int DW = 32,
    parameter int AW = 4
);
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          busy;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata, busy
    );
endinterface

// File: rtl/la_latrf.sv
// DEPTH x DW register file built from word-enabled level-sensitive latches,
// fed by a flopped write stage and followed by a flopped read port.
module la_latrf #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int INIT  = 1,
    parameter     PROP  = "DEFAULT"
) (
    input logic        clk,
    input logic        nreset,
    la_latrf_if.slave  bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam state_t        RST_STATE = (INIT == 1) ? CLEAR : IDLE;
    localparam logic          RST_BUSY  = (INIT == 1);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          busy_reg, busy_next;
    logic [DW-1:0] rdata_reg, rdata_next;

    // Write stage: these flops drive the latch array during the low phase.
    logic          en_q, en_next;
    logic [AW-1:0] addr_q, addr_next;
    logic [DW-1:0] data_q, data_next;

    logic [DEPTH-1:0] word_en;
    logic [DW-1:0]    words [DEPTH];

    logic waddr_ok;
    logic raddr_ok;

    assign waddr_ok = (int'(bus.waddr) < DEPTH);
    assign raddr_ok = (int'(bus.raddr) < DEPTH);

    // PROP only tags the instance for implementation selection.
    if ($bits(PROP) == 0) begin : g_prop_none
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg <= RST_STATE;
            cnt_reg   <= '0;
            busy_reg  <= RST_BUSY;
            en_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= busy_next;
            en_q      <= en_next;
            addr_q    <= addr_next;
            data_q    <= data_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy_next  = 1'b0;
        en_next    = 1'b0;
        addr_next  = addr_q;
        data_next  = data_q;
        case (state_reg)
            CLEAR: begin
                // User requests are discarded; the sweep owns the write stage.
                en_next   = 1'b1;
                addr_next = cnt_reg;
                data_next = '0;
                busy_next = 1'b1;
                if (cnt_reg == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                en_next   = bus.we & waddr_ok;
                addr_next = bus.waddr;
                data_next = bus.wdata;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latches sample before this edge's write opens a word, so a same-edge
    // read returns the previous contents.
    always_comb begin
        rdata_next = '0;
        if (!busy_reg && raddr_ok) begin
            rdata_next = words[bus.raddr];
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [DW-1:0] word_q;

        // Address decode keeps at most one word open per low phase.
        assign word_en[gi] = ~clk & en_q & (addr_q == AW'(gi));

        always_latch begin
            if (word_en[gi]) begin
                word_q = data_q;
            end
        end

        assign words[gi] = word_q;
    end

    assign bus.rdata = rdata_reg;
    assign bus.busy  = busy_reg;

endmodule
